// File: rtl/cmov_ham_seq_pkg.sv
// rtl/cmov_ham_seq_pkg.sv - shared widths, opcodes and FSM encoding for the CMOV/HAM sequencer
package cmov_ham_pkg;

    localparam int REG_IDX_W = 4;
    localparam int DATA_W    = 32;
    localparam int POP_W     = 6;

    // Command opcodes as they arrive from decode
    typedef enum logic [1:0] {
        OP_MOVE  = 2'b00,
        OP_CMOVN = 2'b01,
        OP_CMOVZ = 2'b10,
        OP_HAM   = 2'b11
    } op_e;

    // Sequencer states, kept as plain constants so the state register is a bare vector
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Write condition: conditional moves look only at the second operand
    function automatic logic write_cond(input logic [1:0] op, input logic [DATA_W-1:0] opb);
        logic w;
        case (op)
            OP_CMOVN: w = (opb != '0);
            OP_CMOVZ: w = (opb == '0);
            default:  w = 1'b1;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/cmov_ham_seq_if.sv
// rtl/cmov_ham_seq_if.sv - command, completion and register-bank signals of the sequencer
interface cmov_ham_if;
    import cmov_ham_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [REG_IDX_W-1:0] cmd_rs;
    logic [REG_IDX_W-1:0] cmd_rt;
    logic [REG_IDX_W-1:0] cmd_rd;

    logic [REG_IDX_W-1:0] rb_rs;
    logic [REG_IDX_W-1:0] rb_rt;
    logic [REG_IDX_W-1:0] rb_rd;
    logic                 rb_read;
    logic                 rb_write;
    logic                 rb_enable;
    logic [DATA_W-1:0]    rb_in1;
    logic [DATA_W-1:0]    rb_out1;
    logic [DATA_W-1:0]    rb_out2;

    logic                 done;
    logic                 done_wrote;
    logic [DATA_W-1:0]    result;

    // Sequencer side: takes commands and bank read data, drives everything else
    modport slave (
        input  cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, rb_out1, rb_out2,
        output cmd_ready, rb_rs, rb_rt, rb_rd, rb_read, rb_write, rb_enable, rb_in1,
        output done, done_wrote, result
    );

    // Environment side: decode stage plus register bank
    modport master (
        output cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, rb_out1, rb_out2,
        input  cmd_ready, rb_rs, rb_rt, rb_rd, rb_read, rb_write, rb_enable, rb_in1,
        input  done, done_wrote, result
    );

endinterface

// File: rtl/cmov_ham_seq_popcnt32.sv
// rtl/cmov_ham_seq_popcnt32.sv - combinational 32-bit population count
module popcnt32 (
    input  logic [31:0] i_data,
    output logic [5:0]  o_count
);

    // Ripple sum of set bits; 32 fits in 6 bits
    always_comb begin
        o_count = '0;
        for (int i = 0; i < 32; i++) begin
            o_count = o_count + {5'd0, i_data[i]};
        end
    end

endmodule

// File: rtl/cmov_ham_seq.sv
// rtl/cmov_ham_seq.sv - read/exec/write sequencer for MOVE, CMOVN, CMOVZ and HAM
module cmov_ham_seq
    import cmov_ham_pkg::*;
(
    input  logic       clk,
    input  logic       reset_all,
    cmov_ham_if.slave  bus
);

    logic [2:0]           r_state;
    logic [1:0]           r_op;
    logic [REG_IDX_W-1:0] r_rs;
    logic [REG_IDX_W-1:0] r_rt;
    logic [REG_IDX_W-1:0] r_rd;
    logic [DATA_W-1:0]    r_opa;
    logic [DATA_W-1:0]    r_opb;
    logic [DATA_W-1:0]    r_calc;
    logic                 r_wr;
    logic [DATA_W-1:0]    r_result;

    logic                 w_ready;
    logic                 w_accept;
    logic [POP_W-1:0]     w_pop;
    logic [DATA_W-1:0]    w_calc;
    logic                 w_wr;

    assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_accept = bus.cmd_valid && w_ready;

    popcnt32 u_popcnt (
        .i_data  (r_opa ^ r_opb),
        .o_count (w_pop)
    );

    assign w_calc = (r_op == OP_HAM) ? {{(DATA_W-POP_W){1'b0}}, w_pop} : r_opa;
    assign w_wr   = write_cond(r_op, r_opb);

    // Fixed READ->EXEC->WRITE->DONE walk; DONE can take the next command directly
    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  r_state <= w_accept ? ST_READ : ST_IDLE;
                ST_READ:  r_state <= ST_EXEC;
                ST_EXEC:  r_state <= ST_WRITE;
                ST_WRITE: r_state <= ST_DONE;
                ST_DONE:  r_state <= w_accept ? ST_READ : ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Capture the command fields at acceptance; they stay stable for the whole sequence
    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            r_op <= '0;
            r_rs <= '0;
            r_rt <= '0;
            r_rd <= '0;
        end else if (w_accept) begin
            r_op <= bus.cmd_op;
            r_rs <= bus.cmd_rs;
            r_rt <= bus.cmd_rt;
            r_rd <= bus.cmd_rd;
        end
    end

    // Bank read data is only meaningful at the edge closing READ
    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            r_opa <= '0;
            r_opb <= '0;
        end else if (r_state == ST_READ) begin
            r_opa <= bus.rb_out1;
            r_opb <= bus.rb_out2;
        end
    end

    // Register the computed value and write decision so WRITE drives the bank from flops
    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            r_calc <= '0;
            r_wr   <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_calc <= w_calc;
            r_wr   <= w_wr;
        end
    end

    // Visible result changes only as the command completes, so it is valid alongside done
    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            r_result <= '0;
        end else if (r_state == ST_WRITE) begin
            r_result <= r_calc;
        end
    end

    // Moore decode: a reset forces IDLE, which drops the strobes without waiting for a clock
    assign bus.cmd_ready  = w_ready;
    assign bus.rb_read    = (r_state == ST_READ);
    assign bus.rb_write   = (r_state == ST_WRITE) && r_wr;
    assign bus.rb_enable  = (r_state == ST_READ) || ((r_state == ST_WRITE) && r_wr);
    assign bus.rb_rs      = (r_state == ST_READ)  ? r_rs   : '0;
    assign bus.rb_rt      = (r_state == ST_READ)  ? r_rt   : '0;
    assign bus.rb_rd      = (r_state == ST_WRITE) ? r_rd   : '0;
    assign bus.rb_in1     = (r_state == ST_WRITE) ? r_calc : '0;
    assign bus.done       = (r_state == ST_DONE);
    assign bus.done_wrote = (r_state == ST_DONE) && r_wr;
    assign bus.result     = r_result;

endmodule

// File: tb/tb_cmov_ham_seq.sv
// tb/tb_cmov_ham_seq.sv - directed scoreboard bench for cmov_ham_seq with a behavioural register bank
module tb_cmov_ham_seq;
    import cmov_ham_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic        wrote;
    } exp_t;

    logic clk = 1'b0;
    logic reset_all;
    int   checks = 0;
    int   errors = 0;
    int   wr_pulses = 0;
    exp_t sb[$];

    logic [31:0] regs [16];
    logic        pl_en;
    logic [3:0]  pl_idx;
    logic [31:0] pl_data;

    always #5 clk = ~clk;

    cmov_ham_if bus ();

    cmov_ham_seq dut (
        .clk       (clk),
        .reset_all (reset_all),
        .bus       (bus)
    );

    // Bank read port: captures on negedge while read and enable
    always @(negedge clk) begin
        if (bus.rb_read && bus.rb_enable) begin
            bus.rb_out1 <= regs[bus.rb_rs];
            bus.rb_out2 <= regs[bus.rb_rt];
        end
    end

    // Bank write port on posedge; bench preload shares the same port
    always @(posedge clk) begin
        if (pl_en) regs[pl_idx] <= pl_data;
        else if (bus.rb_write && bus.rb_enable) regs[bus.rb_rd] <= bus.rb_in1;
    end

    // Count write strobes seen at the commit edge
    always @(posedge clk) begin
        if (bus.rb_write) wr_pulses <= wr_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Drive a command, push its expectation, return just after the accepting edge (valid left high)
    task automatic send(input logic [1:0] op, input logic [3:0] rs, input logic [3:0] rt,
                        input logic [3:0] rd, input logic [31:0] e_res, input logic e_wr);
        int n = 0;
        exp_t e;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op; bus.cmd_rs = rs; bus.cmd_rt = rt; bus.cmd_rd = rd;
        e.res = e_res; e.wrote = e_wr;
        sb.push_back(e);
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_bound", {31'd0, n < 20}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Cycles 1..3 after accept are busy; done must appear in cycle 4
    task automatic wait_done(input string tag);
        exp_t e;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c < 4) begin
                check({tag, "_busy_ready"}, {31'd0, bus.cmd_ready}, 32'd0);
                check({tag, "_busy_done"}, {31'd0, bus.done}, 32'd0);
            end
        end
        check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        check({tag, "_ready_in_done"}, {31'd0, bus.cmd_ready}, 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_result"}, bus.result, e.res);
            check({tag, "_done_wrote"}, {31'd0, bus.done_wrote}, {31'd0, e.wrote});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
        check({tag, "_done"}, {30'd0, bus.done, bus.done_wrote}, 32'd0);
        check({tag, "_strobes"}, {29'd0, bus.rb_read, bus.rb_write, bus.rb_enable}, 32'd0);
        check({tag, "_idx"}, {20'd0, bus.rb_rs, bus.rb_rt, bus.rb_rd}, 32'd0);
        check({tag, "_rb_in1"}, bus.rb_in1, 32'd0);
        check({tag, "_result"}, bus.result, 32'd0);
    endtask

    initial begin
        int p0;
        reset_all = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'b00; bus.cmd_rs = '0; bus.cmd_rt = '0; bus.cmd_rd = '0;
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        reset_all = 1'b0;

        preload(4'd3, 32'h0000_00FF);
        preload(4'd4, 32'h0000_0000);
        preload(4'd5, 32'h5555_5555);
        preload(4'd6, 32'h6666_6666);
        preload(4'd7, 32'h7777_7777);
        preload(4'd1, 32'hFFFF_FFFF);
        preload(4'd2, 32'h0000_0000);
        preload(4'd9, 32'h9999_9999);
        preload(4'd10, 32'h0F0F_0000);
        preload(4'd11, 32'h0000_0003);

        send(OP_MOVE, 4'd3, 4'd0, 4'd5, 32'h0000_00FF, 1'b1);
        bus.cmd_valid = 1'b0;
        wait_done("move");
        check("move_r5", regs[5], 32'h0000_00FF);

        p0 = wr_pulses;
        send(OP_CMOVN, 4'd3, 4'd4, 4'd6, 32'h0000_00FF, 1'b0);
        bus.cmd_valid = 1'b0;
        wait_done("cmovn_skip");
        check("cmovn_skip_r6", regs[6], 32'h6666_6666);
        check("cmovn_skip_no_write", wr_pulses, p0);

        preload(4'd4, 32'h0000_0001);
        send(OP_CMOVN, 4'd3, 4'd4, 4'd6, 32'h0000_00FF, 1'b1);
        bus.cmd_valid = 1'b0;
        wait_done("cmovn_take");
        check("cmovn_take_r6", regs[6], 32'h0000_00FF);

        preload(4'd4, 32'h0000_0000);
        send(OP_CMOVZ, 4'd3, 4'd4, 4'd7, 32'h0000_00FF, 1'b1);
        bus.cmd_valid = 1'b0;
        wait_done("cmovz");
        check("cmovz_r7", regs[7], 32'h0000_00FF);

        send(OP_HAM, 4'd1, 4'd2, 4'd1, 32'd32, 1'b1);
        bus.cmd_valid = 1'b0;
        wait_done("ham32");
        check("ham32_r1", regs[1], 32'd32);

        preload(4'd1, 32'hA5A5_A5A5);
        preload(4'd2, 32'hA5A5_A5A5);
        send(OP_HAM, 4'd1, 4'd2, 4'd1, 32'd0, 1'b1);
        bus.cmd_valid = 1'b0;
        wait_done("ham0");
        check("ham0_r1", regs[1], 32'd0);

        // Second command held during the first and reads the first one's destination
        send(OP_HAM, 4'd10, 4'd11, 4'd12, 32'd10, 1'b1);
        bus.cmd_op = OP_MOVE; bus.cmd_rs = 4'd12; bus.cmd_rt = 4'd0; bus.cmd_rd = 4'd13;
        begin
            exp_t e;
            e.res = 32'd10; e.wrote = 1'b1;
            sb.push_back(e);
        end
        wait_done("b2b_a");
        check("b2b_a_r12", regs[12], 32'd10);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        wait_done("b2b_b");
        check("b2b_b_r13", regs[13], 32'd10);

        // Reset while WRITE is driving the bank
        p0 = wr_pulses;
        send(OP_MOVE, 4'd3, 4'd0, 4'd9, 32'h0000_00FF, 1'b1);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        check("rst_pre_write", {31'd0, bus.rb_write}, 32'd1);
        reset_all = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        sb.delete();
        @(negedge clk);
        check("rst_r9", regs[9], 32'h9999_9999);
        check("rst_no_write", wr_pulses, p0);
        reset_all = 1'b0;
        check("rst_state", {29'd0, dut.r_state}, {29'd0, ST_IDLE});
        repeat (5) @(negedge clk);
        check("rst_after_r9", regs[9], 32'h9999_9999);
        check_reset_outputs("rst_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
